// File: rtl/rec_pkg.sv
// Shared type for the vector recorder: the sweep state machine encoding.
package rec_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;
endpackage

// File: rtl/vec_ram.sv
// Recording table: synchronous write, one-cycle registered read.
// Only the read register is cleared by reset; the array keeps its contents.
module vec_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_data only moves on an accepted read, so a refused read leaves it untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/vector_recorder.sv
// Exhaustive stimulus sweeper: drives every input pattern to an external DUT,
// waits SETTLE cycles, then records {pattern, response} into a table.
module vector_recorder
    import rec_pkg::*;
#(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [IN_W-1:0]       dut_a,
    input  logic [OUT_W-1:0]      dut_y,
    output logic                  busy,
    output logic                  done,
    output logic [IN_W:0]         count,
    input  logic                  rd_en,
    input  logic [IN_W-1:0]       rd_addr,
    output logic [IN_W+OUT_W-1:0] rd_data,
    output logic                  rd_valid
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [IN_W-1:0] LAST_IDX    = {IN_W{1'b1}};

    state_t          state;
    logic [IN_W-1:0] idx;
    logic [SW-1:0]   settle;
    logic            wr_en;
    logic            rd_accept;

    // idx is the pattern register itself, so it holds the last pattern after a sweep
    assign dut_a     = idx;
    assign wr_en     = (state == CAPTURE);
    assign rd_accept = rd_en && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            settle   <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= DRIVE;
                        idx    <= '0;
                        settle <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (settle == SETTLE_LAST) begin
                        state  <= CAPTURE;
                        settle <= '0;
                    end else begin
                        settle <= settle + SW'(1);
                    end
                end
                CAPTURE: begin
                    count <= count + (IN_W+1)'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + IN_W'(1);
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    vec_ram #(
        .ADDR_W(IN_W),
        .DATA_W(IN_W + OUT_W)
    ) table_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(idx),
        .wr_data({idx, dut_y}),
        .rd_en  (rd_accept),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );
endmodule

// File: tb/tb_vector_recorder.sv
// Directed bench for vector_recorder: three instances cover the XOR sweep,
// a longer settle time, and a narrow two-bit-output configuration.
module tb_vector_recorder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       start_a, rd_en_a, y_a, busy_a, done_a, rd_valid_a;
    logic [3:0] dut_a_a, rd_addr_a;
    logic [4:0] count_a, rd_data_a;

    logic       start_s, rd_en_s, y_s, busy_s, done_s, rd_valid_s;
    logic [3:0] dut_a_s, rd_addr_s;
    logic [4:0] count_s, rd_data_s;

    logic       start_n, rd_en_n, busy_n, done_n, rd_valid_n;
    logic [1:0] dut_a_n, rd_addr_n, y_n;
    logic [2:0] count_n;
    logic [3:0] rd_data_n;

    // Models of the external DUTs under test
    assign y_a = ^dut_a_a;
    assign y_s = ^dut_a_s;
    assign y_n = {&dut_a_n, |dut_a_n};

    int checks = 0;
    int passed = 0;

    vector_recorder #(.IN_W(4), .OUT_W(1), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start_a), .dut_a(dut_a_a), .dut_y(y_a),
        .busy(busy_a), .done(done_a), .count(count_a), .rd_en(rd_en_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

    vector_recorder #(.IN_W(4), .OUT_W(1), .SETTLE(3)) dut_slow (
        .clk(clk), .reset(reset), .start(start_s), .dut_a(dut_a_s), .dut_y(y_s),
        .busy(busy_s), .done(done_s), .count(count_s), .rd_en(rd_en_s),
        .rd_addr(rd_addr_s), .rd_data(rd_data_s), .rd_valid(rd_valid_s));

    vector_recorder #(.IN_W(2), .OUT_W(2), .SETTLE(1)) dut_narrow (
        .clk(clk), .reset(reset), .start(start_n), .dut_a(dut_a_n), .dut_y(y_n),
        .busy(busy_n), .done(done_n), .count(count_n), .rd_en(rd_en_n),
        .rd_addr(rd_addr_n), .rd_data(rd_data_n), .rd_valid(rd_valid_n));

    task automatic test_reset();
        reset = 1'b1;
        start_a = 0; rd_en_a = 0; rd_addr_a = '0;
        start_s = 0; rd_en_s = 0; rd_addr_s = '0;
        start_n = 0; rd_en_n = 0; rd_addr_n = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
        checks++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passed++;
        checks++; if (count_a !== 5'd0) $display("FAIL reset_count: got %0d want 0", count_a); else passed++;
        checks++; if (dut_a_a !== 4'd0) $display("FAIL reset_dut_a: got %0d want 0", dut_a_a); else passed++;
        checks++; if (rd_valid_a !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid_a); else passed++;
        checks++; if (rd_data_a !== 5'd0) $display("FAIL reset_rd_data: got %b want 0", rd_data_a); else passed++;
    endtask

    task automatic test_read_busy();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rd_en_a = (k == 10);
            rd_addr_a = 4'd2;
            if (k == 11) begin
                checks++; if (rd_valid_a !== 1'b0) $display("FAIL busy_read_valid: got %b want 0", rd_valid_a); else passed++;
                checks++; if (rd_data_a !== 5'd0) $display("FAIL busy_read_data: got %b want 00000", rd_data_a); else passed++;
            end
            @(negedge clk);
        end
        rd_en_a = 1'b0;
    endtask

    task automatic test_sweep();
        int busy_cnt = 0, done_cnt = 0, first_done = -1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy_a) busy_cnt++;
            if (done_a) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            @(negedge clk);
        end
        checks++; if (busy_cnt != 32) $display("FAIL sweep_busy_cycles: got %0d want 32", busy_cnt); else passed++;
        checks++; if (first_done != 32) $display("FAIL sweep_done_time: got %0d want 32", first_done); else passed++;
        checks++; if (done_cnt != 1) $display("FAIL sweep_done_pulses: got %0d want 1", done_cnt); else passed++;
        checks++; if (count_a !== 5'd16) $display("FAIL sweep_count: got %0d want 16", count_a); else passed++;
        checks++; if (dut_a_a !== 4'd15) $display("FAIL sweep_dut_a_hold: got %0d want 15", dut_a_a); else passed++;
    endtask

    task automatic test_read();
        logic [3:0] addrs [3] = '{4'd5, 4'd7, 4'd2};
        logic [4:0] exps  [3] = '{5'b01010, 5'b01111, 5'b00101};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_en_a = 1'b1;
            rd_addr_a = addrs[i];
            @(negedge clk);
            rd_en_a = 1'b0;
            checks++; if (rd_valid_a !== 1'b1) $display("FAIL read_valid[%0d]: got %b want 1", addrs[i], rd_valid_a); else passed++;
            checks++; if (rd_data_a !== exps[i]) $display("FAIL read_data[%0d]: got %b want %b", addrs[i], rd_data_a, exps[i]); else passed++;
            @(negedge clk);
            checks++; if (rd_valid_a !== 1'b0) $display("FAIL read_valid_drop[%0d]: got %b want 0", addrs[i], rd_valid_a); else passed++;
        end
    endtask

    task automatic test_start_ignored();
        int done_cnt = 0, first_done = -1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_a) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            start_a = (k == 3) || (k == 20);
            @(negedge clk);
        end
        start_a = 1'b0;
        checks++; if (first_done != 32) $display("FAIL restart_done_time: got %0d want 32", first_done); else passed++;
        checks++; if (done_cnt != 1) $display("FAIL restart_done_pulses: got %0d want 1", done_cnt); else passed++;
        checks++; if (count_a !== 5'd16) $display("FAIL restart_count: got %0d want 16", count_a); else passed++;
    endtask

    task automatic test_mid_reset();
        int done_cnt = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int k = 0; k < 13; k++) @(negedge clk);
        checks++; if (dut_a_a !== 4'd6) $display("FAIL midreset_pre_dut_a: got %0d want 6", dut_a_a); else passed++;
        checks++; if (count_a !== 5'd6) $display("FAIL midreset_pre_count: got %0d want 6", count_a); else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy_a !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy_a); else passed++;
        checks++; if (count_a !== 5'd0) $display("FAIL midreset_count: got %0d want 0", count_a); else passed++;
        checks++; if (dut_a_a !== 4'd0) $display("FAIL midreset_dut_a: got %0d want 0", dut_a_a); else passed++;
        checks++; if (rd_data_a !== 5'd0) $display("FAIL midreset_rd_data: got %b want 0", rd_data_a); else passed++;
        for (int k = 0; k < 40; k++) begin
            if (done_a) done_cnt++;
            @(negedge clk);
        end
        checks++; if (done_cnt != 0) $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt); else passed++;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_a) done_cnt++;
            @(negedge clk);
        end
        checks++; if (done_cnt != 1) $display("FAIL midreset_resweep_done: got %0d want 1", done_cnt); else passed++;
        checks++; if (count_a !== 5'd16) $display("FAIL midreset_resweep_count: got %0d want 16", count_a); else passed++;
    endtask

    task automatic test_settle3();
        int done_cnt = 0, first_done = -1;
        logic [3:0] exp_a;
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (k < 64) begin
                exp_a = 4'(k / 4);
                checks++; if (dut_a_s !== exp_a) $display("FAIL settle3_hold[%0d]: got %0d want %0d", k, dut_a_s, exp_a); else passed++;
            end
            if (done_s) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            @(negedge clk);
        end
        checks++; if (first_done != 64) $display("FAIL settle3_done_time: got %0d want 64", first_done); else passed++;
        checks++; if (done_cnt != 1) $display("FAIL settle3_done_pulses: got %0d want 1", done_cnt); else passed++;
        checks++; if (count_s !== 5'd16) $display("FAIL settle3_count: got %0d want 16", count_s); else passed++;
    endtask

    task automatic test_narrow();
        int first_done = -1;
        logic [3:0] exps [4] = '{4'b0000, 4'b0101, 4'b1001, 4'b1111};
        @(negedge clk) start_n = 1'b1;
        @(negedge clk) start_n = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (done_n && first_done < 0) first_done = k;
            @(negedge clk);
        end
        checks++; if (first_done != 8) $display("FAIL narrow_done_time: got %0d want 8", first_done); else passed++;
        checks++; if (count_n !== 3'd4) $display("FAIL narrow_count: got %0d want 4", count_n); else passed++;
        for (int i = 0; i < 4; i++) begin
            rd_en_n = 1'b1;
            rd_addr_n = 2'(i);
            @(negedge clk);
            rd_en_n = 1'b0;
            checks++; if (rd_valid_n !== 1'b1) $display("FAIL narrow_valid[%0d]: got %b want 1", i, rd_valid_n); else passed++;
            checks++; if (rd_data_n !== exps[i]) $display("FAIL narrow_data[%0d]: got %b want %b", i, rd_data_n, exps[i]); else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_read_busy();
        test_sweep();
        test_read();
        test_start_ignored();
        test_mid_reset();
        test_settle3();
        test_narrow();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
